// File: rtl/aurora_arb_pkg.sv
// aurora_arb_pkg
// Shared types and constants for the Aurora TX arbiter slice:
//   arb_state_t  - arbiter FSM state (IDLE, XFER)
//   NUM_SRC_MAX  - largest supported number of requesting sources
//   GRANT_W      - width of a source index / grant_id
//   CNT_W        - width of the packet statistics counter
//   rr_pick()    - round-robin search helper
package aurora_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int NUM_SRC_MAX = 8;
  localparam int GRANT_W     = 3;
  localparam int CNT_W       = 32;

  // Round-robin search over the first n request bits, starting just after
  // 'last' and wrapping. Returns {found, index}. The loop runs from the
  // farthest candidate to the nearest so the nearest requester is the final
  // assignment and therefore the winner; no early exit is needed.
  function automatic logic [GRANT_W:0] rr_pick(
    input logic [NUM_SRC_MAX-1:0] req,
    input logic [GRANT_W-1:0]     last,
    input int                     n
  );
    logic [GRANT_W:0] res;
    int               idx;
    res = '0;
    for (int k = NUM_SRC_MAX; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= n) idx = idx - n;
      if ((k <= n) && req[idx[GRANT_W-1:0]]) begin
        res = {1'b1, idx[GRANT_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aurora_axis_skid.sv
// aurora_axis_skid
// Two-entry AXI-Stream register slice carrying {tdata, tkeep, tlast}.
// 'main' drives the outputs; 'spare' absorbs the one beat that may arrive
// in the cycle the downstream stalls, so in_ready can be a plain register
// term and the path still runs at one beat per cycle.
//   clk, rst_n                         - clock, async active-low reset
//   in_valid/in_ready/in_data/keep/last - upstream side
//   out_valid/out_ready/out_data/keep/last - downstream side (registered)
module aurora_axis_skid
  import aurora_arb_pkg::*;
#(
  parameter int DATA_WD = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_WD-1:0]   in_data,
  input  logic [DATA_WD/8-1:0] in_keep,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_WD-1:0]   out_data,
  output logic [DATA_WD/8-1:0] out_keep,
  output logic                 out_last
);

  localparam int PAY_W = DATA_WD + DATA_WD/8 + 1;

  logic [PAY_W-1:0] main_reg, spare_reg, in_pay;
  logic             main_vld_reg, spare_vld_reg;
  logic             in_hs, out_hs;

  assign in_pay   = {in_data, in_keep, in_last};
  assign in_ready = !spare_vld_reg;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = main_vld_reg && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_reg      <= '0;
      spare_reg     <= '0;
      main_vld_reg  <= 1'b0;
      spare_vld_reg <= 1'b0;
    end else if (out_hs) begin
      if (spare_vld_reg) begin
        // in_ready is low while spare holds a beat, so no new beat here
        main_reg      <= spare_reg;
        spare_vld_reg <= 1'b0;
      end else begin
        main_vld_reg <= in_hs;
        if (in_hs) main_reg <= in_pay;
      end
    end else if (in_hs) begin
      if (!main_vld_reg) begin
        main_vld_reg <= 1'b1;
        main_reg     <= in_pay;
      end else begin
        spare_vld_reg <= 1'b1;
        spare_reg     <= in_pay;
      end
    end
  end

  assign out_valid = main_vld_reg;
  assign {out_data, out_keep, out_last} = main_reg;

endmodule

// File: rtl/cmip_app_cnt.sv
// cmip_app_cnt
// Saturating event counter with synchronous clear.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear; has priority over inc
//   inc        - count enable, one per cycle
//   cnt        - current count, sticks at all-ones
module cmip_app_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {WIDTH{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/aurora_tx_arbiter.sv
// aurora_tx_arbiter
// Packet-level round-robin arbiter sharing one Aurora TX AXI-Stream channel
// among NUM_SRC message generators. A grant is held from the first beat to
// the tlast beat, so packets never interleave. Output is registered through
// aurora_axis_skid.
//   clk, rst_n       - clock, asynchronous active-low reset
//   cfg_rst          - synchronous clear of arb_pkt_cnt only
//   s_axis_*         - NUM_SRC packed source streams (source i at slice i)
//   m_axis_*         - merged stream to the Aurora TX user interface
//   grant_id         - current or most recent granted source
//   arb_pkt_cnt      - packets forwarded (output tlast handshakes), saturating
// Build option: define AURORA_TX_ARB_SP_EN to give source 0 strict priority
// at packet boundaries (others keep round-robin among themselves).
module aurora_tx_arbiter
  import aurora_arb_pkg::*;
#(
  parameter int DATA_WD = 64,
  parameter int NUM_SRC = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_rst,
  input  logic [NUM_SRC*DATA_WD-1:0]   s_axis_tdata,
  input  logic [NUM_SRC*DATA_WD/8-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]           s_axis_tvalid,
  input  logic [NUM_SRC-1:0]           s_axis_tlast,
  output logic [NUM_SRC-1:0]           s_axis_tready,
  output logic [DATA_WD-1:0]           m_axis_tdata,
  output logic [DATA_WD/8-1:0]         m_axis_tkeep,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,
  output logic [GRANT_W-1:0]           grant_id,
  output logic [CNT_W-1:0]             arb_pkt_cnt
);

  localparam int KEEP_WD = DATA_WD/8;

  arb_state_t         state_reg;
  logic [GRANT_W-1:0] grant_reg, last_grant_reg;

  // Sources unpacked into NUM_SRC_MAX-deep arrays so a GRANT_W-bit index
  // always lands on a real element; unused slots read as idle.
  logic [DATA_WD-1:0]     src_data [NUM_SRC_MAX];
  logic [KEEP_WD-1:0]     src_keep [NUM_SRC_MAX];
  logic [NUM_SRC_MAX-1:0] req_vec, last_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC_MAX; gi++) begin : g_unpack
      if (gi < NUM_SRC) begin : g_used
        assign src_data[gi] = s_axis_tdata[gi*DATA_WD +: DATA_WD];
        assign src_keep[gi] = s_axis_tkeep[gi*KEEP_WD +: KEEP_WD];
        assign req_vec[gi]  = s_axis_tvalid[gi];
        assign last_vec[gi] = s_axis_tlast[gi];
      end else begin : g_unused
        assign src_data[gi] = '0;
        assign src_keep[gi] = '0;
        assign req_vec[gi]  = 1'b0;
        assign last_vec[gi] = 1'b0;
      end
    end
  endgenerate

  // Winner selection for the IDLE cycle
  logic [GRANT_W:0]   rr_res;
  logic [GRANT_W-1:0] winner;
  logic               win_found, upd_last;

  always_comb begin
    rr_res    = rr_pick(req_vec, last_grant_reg, NUM_SRC);
    winner    = rr_res[GRANT_W-1:0];
    win_found = rr_res[GRANT_W];
    upd_last  = 1'b1;
`ifdef AURORA_TX_ARB_SP_EN
    // Source 0 jumps the queue but leaves the rotation pointer alone, so
    // the other sources resume where they left off.
    if (req_vec[0]) begin
      winner    = '0;
      win_found = 1'b1;
      upd_last  = 1'b0;
    end
`endif
  end

  // Datapath from the granted source into the skid slice
  logic skid_in_ready, skid_in_valid, src_hs, xfer;

  assign xfer          = (state_reg == XFER);
  assign skid_in_valid = xfer && req_vec[grant_reg];
  assign src_hs        = skid_in_valid && skid_in_ready;

  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_ready
      assign s_axis_tready[gi] = xfer && skid_in_ready && (grant_reg == GRANT_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GRANT_W'(NUM_SRC-1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            state_reg <= XFER;
            grant_reg <= winner;
            if (upd_last) last_grant_reg <= winner;
          end
        end
        XFER: begin
          // A stalled source only pauses the packet; the grant is kept
          if (src_hs && last_vec[grant_reg]) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant_id = grant_reg;

  aurora_axis_skid #(
    .DATA_WD (DATA_WD)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .in_data   (src_data[grant_reg]),
    .in_keep   (src_keep[grant_reg]),
    .in_last   (last_vec[grant_reg]),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (m_axis_tdata),
    .out_keep  (m_axis_tkeep),
    .out_last  (m_axis_tlast)
  );

  cmip_app_cnt #(
    .WIDTH (CNT_W)
  ) u_pkt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cfg_rst),
    .inc   (m_axis_tvalid && m_axis_tready && m_axis_tlast),
    .cnt   (arb_pkt_cnt)
  );

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// tb_aurora_tx_arbiter
// Directed bench for aurora_tx_arbiter (DATA_WD=64, NUM_SRC=4). Per-source
// drivers play beat tables; expected output beats and grant order are
// pushed into queues and checked by an independent output monitor.
module tb_aurora_tx_arbiter;

  localparam int DW = 64;
  localparam int NS = 4;
  localparam int KW = DW/8;

  logic             clk, rst_n, cfg_rst;
  logic [NS*DW-1:0] s_data;
  logic [NS*KW-1:0] s_keep;
  logic [NS-1:0]    s_valid, s_last, s_ready;
  logic [DW-1:0]    m_data;
  logic [KW-1:0]    m_keep;
  logic             m_valid, m_last, m_ready;
  logic [2:0]       grant_id;
  logic [31:0]      pkt_cnt;

  aurora_tx_arbiter #(.DATA_WD(DW), .NUM_SRC(NS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
    .s_axis_tlast(s_last), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
    .m_axis_tlast(m_last), .m_axis_tready(m_ready),
    .grant_id(grant_id), .arb_pkt_cnt(pkt_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  beat_t  exp_q[$];
  int     exp_grant_q[$];
  beat_t  tbl [NS][64];
  int     gap_tbl [NS][64];
  int     rd [NS];
  int     wr [NS];
  int     gap_c [NS];
  bit     cur_ld [NS];
  bit     pkt_act [NS];
  int     sop_cyc [NS];
  int     fill_events = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // ---------------- source drivers ----------------
  initial begin
    logic [NS-1:0] hs_s;
    int g;
    for (int s = 0; s < NS; s++) begin
      rd[s] = 0; wr[s] = 0; gap_c[s] = 0; cur_ld[s] = 0; pkt_act[s] = 0; sop_cyc[s] = 0;
    end
    forever begin
      @(negedge clk);
      hs_s = s_valid & s_ready;
      for (int s = 0; s < NS; s++) begin
        if (hs_s[s] && !pkt_act[s]) begin
          sop_cyc[s] = cyc;
          if (exp_grant_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL grant_order: src %0d granted, none expected", s);
          end else begin
            g = exp_grant_q.pop_front();
            chk("grant_order", 64'(s), 64'(g));
            chk("grant_id_at_sop", 64'(grant_id), 64'(s));
          end
        end
      end
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) begin
        if (hs_s[s]) begin
          pkt_act[s] = !tbl[s][rd[s]].last;
          rd[s]      = rd[s] + 1;
          cur_ld[s]  = 0;
        end else if (cur_ld[s] && gap_c[s] > 0) begin
          gap_c[s] = gap_c[s] - 1;
        end
        if (!cur_ld[s] && rd[s] != wr[s]) begin
          cur_ld[s] = 1;
          gap_c[s]  = gap_tbl[s][rd[s]];
        end
        s_valid[s] = cur_ld[s] && (gap_c[s] == 0);
        s_data[s*DW +: DW] = cur_ld[s] ? tbl[s][rd[s]].data : '0;
        s_keep[s*KW +: KW] = cur_ld[s] ? tbl[s][rd[s]].keep : '0;
        s_last[s]          = cur_ld[s] ? tbl[s][rd[s]].last : 1'b0;
      end
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    logic          prev_v, prev_r, fill_prev, fill_now;
    logic [DW-1:0] prev_d;
    beat_t         e;
    prev_v = 0; prev_r = 0; fill_prev = 0; prev_d = '0;
    forever begin
      @(negedge clk);
      fill_now = 0;
      if (rst_n) begin
        if (prev_v && !prev_r) begin
          chk("m_valid_hold", 64'(m_valid), 64'd1);
          chk("m_data_hold", m_data, prev_d);
        end
        if (fill_prev) chk("s_ready_after_spare_fill", 64'(s_ready), 64'd0);
        for (int s = 0; s < NS; s++) begin
          if (pkt_act[s]) begin
            chk("grant_held", 64'(grant_id), 64'(s));
            chk("ready_only_granted", 64'(s_ready & ~(4'b0001 << s)), 64'd0);
          end
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL m_beat: unexpected beat data %0h, nothing expected", m_data);
          end else begin
            e = exp_q.pop_front();
            chk("m_tdata", m_data, e.data);
            chk("m_tkeep", 64'(m_keep), 64'(e.keep));
            chk("m_tlast", 64'(m_last), 64'(e.last));
          end
        end
        fill_now = m_valid && !m_ready && (|(s_valid & s_ready));
        if (fill_now) fill_events++;
      end
      prev_v = rst_n && m_valid; prev_r = m_ready; prev_d = m_data;
      fill_prev = fill_now;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic ld(input int s, input logic [DW-1:0] d, input logic [KW-1:0] k,
                    input logic l, input int gap);
    tbl[s][wr[s]]     = '{data: d, keep: k, last: l};
    gap_tbl[s][wr[s]] = gap;
    wr[s] = wr[s] + 1;
  endtask

  function automatic logic [DW-1:0] pdata(input int s, input int tag, input int b);
    logic [DW-1:0] d;
    d = 64'hA000_0000_0000_0000 | (64'(tag) << 16) | (64'(s) << 8) | 64'(b);
    return d;
  endfunction

  // Load an n-beat packet; gap0 delays the first beat, gap1 the second
  task automatic pkt(input int s, input int n, input int tag, input int gap0, input int gap1);
    for (int b = 0; b < n; b++)
      ld(s, pdata(s, tag, b), (b == n-1) ? 8'h0F : 8'hFF, b == n-1,
         (b == 0) ? gap0 : ((b == 1) ? gap1 : 0));
  endtask

  task automatic exp_pkt(input int s, input int n, input int tag);
    for (int b = 0; b < n; b++)
      exp_q.push_back('{data: pdata(s, tag, b), keep: (b == n-1) ? 8'h0F : 8'hFF, last: b == n-1});
    exp_grant_q.push_back(s);
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (exp_grant_q.size() == 0) && !m_valid;
      for (int s = 0; s < NS; s++) if (rd[s] != wr[s] || cur_ld[s]) done = 0;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: not drained after %0d cycles, %0d beats pending", name, budget, exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_valid), 64'd0);
    chk("rst_m_tdata", m_data, 64'd0);
    chk("rst_m_tkeep", 64'(m_keep), 64'd0);
    chk("rst_m_tlast", 64'(m_last), 64'd0);
    chk("rst_s_tready", 64'(s_ready), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic wait_mvalid_pos(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      seen = m_valid;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: m_axis_tvalid never rose within %0d cycles", name, budget);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bit seen;
    rst_n = 0; cfg_rst = 0; m_ready = 1;
    s_valid = '0; s_last = '0; s_data = '0; s_keep = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // T1: single 3-beat packet from source 2
    @(negedge clk);
    ld(2, 64'h55aa_0001, 8'hFF, 0, 0);
    ld(2, 64'h1, 8'hFF, 0, 0);
    ld(2, 64'h2, 8'hFF, 1, 0);
    exp_q.push_back('{data: 64'h55aa_0001, keep: 8'hFF, last: 1'b0});
    exp_q.push_back('{data: 64'h1, keep: 8'hFF, last: 1'b0});
    exp_q.push_back('{data: 64'h2, keep: 8'hFF, last: 1'b1});
    exp_grant_q.push_back(2);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = m_valid;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL t1_first_beat: no output within 20 cycles");
    end else begin
      chk("t1_latency_cycles", 64'(cyc - sop_cyc[2]), 64'd1);
    end
    wait_drain("t1_drain", 40);
    chk("t1_grant_id", 64'(grant_id), 64'd2);
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
    $display("T1 single packet src2 done, pkt_cnt=%0d", pkt_cnt);

    // T2: fairness, all sources continuous 2-beat packets
    do_reset();
    @(negedge clk);
    pkt(0, 2, 1, 0, 0); pkt(0, 2, 2, 0, 0);
    pkt(1, 2, 1, 0, 0); pkt(2, 2, 1, 0, 0); pkt(3, 2, 1, 0, 0);
    exp_pkt(0, 2, 1); exp_pkt(1, 2, 1); exp_pkt(2, 2, 1); exp_pkt(3, 2, 1); exp_pkt(0, 2, 2);
    wait_drain("t2_drain", 80);
    chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd5);
    $display("T2 fairness order 0,1,2,3,0 done, pkt_cnt=%0d", pkt_cnt);

    // T3: back-pressure 1,0,0,1 during a 4-beat packet from source 3
    fill_events = 0;
    @(negedge clk);
    pkt(3, 4, 3, 0, 0);
    exp_pkt(3, 4, 3);
    wait_mvalid_pos("t3_first_beat", 20);
    @(posedge clk); #1; m_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1; m_ready = 1;
    wait_drain("t3_drain", 40);
    chk("t3_spare_fill_events", 64'(fill_events), 64'd1);
    chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd6);
    $display("T3 back-pressure packet done, fills=%0d", fill_events);

    // T4: source 1 stalls 5 cycles mid-packet while source 0 requests
    @(negedge clk);
    pkt(1, 3, 4, 0, 5);
    pkt(0, 1, 4, 2, 0);
    exp_pkt(1, 3, 4); exp_pkt(0, 1, 4);
    wait_drain("t4_drain", 60);
    chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd8);
    $display("T4 mid-packet stall done, grant_id=%0d", grant_id);

    // T5: cfg_rst coincident with a tlast handshake at pkt_cnt=7
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      pkt(0, 1, 5, 0, 0);
      exp_pkt(0, 1, 5);
    end
    wait_drain("t5_fill_drain", 60);
    chk("t5_pkt_cnt_before", 64'(pkt_cnt), 64'd7);
    @(posedge clk); #1; m_ready = 0;
    @(negedge clk);
    pkt(0, 1, 6, 0, 0);
    exp_pkt(0, 1, 6);
    wait_mvalid_pos("t5_first_beat", 20);
    cfg_rst = 1; m_ready = 1;
    @(posedge clk); #1; cfg_rst = 0;
    @(negedge clk);
    chk("t5_cfg_rst_wins", 64'(pkt_cnt), 64'd0);
    wait_drain("t5_drain", 20);
    @(negedge clk);
    pkt(0, 1, 7, 0, 0);
    exp_pkt(0, 1, 7);
    wait_drain("t5_post_drain", 20);
    chk("t5_pkt_cnt_after", 64'(pkt_cnt), 64'd1);
    $display("T5 cfg_rst collision done, pkt_cnt=%0d", pkt_cnt);

    // T6: src3 in progress, src0 (two packets) and src1 waiting
    @(negedge clk);
    pkt(3, 3, 8, 0, 0);
    pkt(0, 1, 8, 2, 0);
    pkt(0, 1, 9, 0, 0);
    pkt(1, 1, 8, 2, 0);
    exp_pkt(3, 3, 8);
`ifdef AURORA_TX_ARB_SP_EN
    exp_pkt(0, 1, 8); exp_pkt(0, 1, 9); exp_pkt(1, 1, 8);
`else
    exp_pkt(0, 1, 8); exp_pkt(1, 1, 8); exp_pkt(0, 1, 9);
`endif
    wait_drain("t6_drain", 60);
    chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd5);
    $display("T6 priority/round-robin after src3 done, grant_id=%0d", grant_id);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
